// File: rtl/cell_loader.sv
// Streams PORT_WIDTH-bit configuration words onto a shared row bus and pulses one
// slot write enable per word. Optional checksum output: define CELL_LOADER_CHECKSUM_EN.
module cell_loader #(
    parameter int DIMX       = 64,
    parameter int DIMY       = 16,
    parameter int PORT_WIDTH = 32,
    parameter int SLOTS      = DIMX * 4 / PORT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [PORT_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DIMX*4-1:0]       ram,
    output logic [DIMY*SLOTS-1:0]   write_en,
    output logic                    busy,
    output logic                    done
`ifdef CELL_LOADER_CHECKSUM_EN
    ,
    output logic [PORT_WIDTH-1:0]   checksum
`endif
);

    localparam int ROW_W  = (DIMY > 1) ? $clog2(DIMY) : 1;
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(DIMY - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ROW_W-1:0]    r_row;
    logic [SLOT_W-1:0]   r_slot;
    logic [DIMX*4-1:0]   r_ram;
    logic                w_accept;
    logic                w_start_load;
    logic                w_slot_last;
    logic                w_row_last;

    assign w_accept     = (r_state == LOAD) && in_valid;
    assign w_start_load = (r_state == IDLE) && start;
    assign w_slot_last  = (r_slot == SLOT_LAST);
    assign w_row_last   = (r_row == ROW_LAST);
    assign ram          = r_ram;

    // NOTE: state and data registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        write_en = '0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = WRITE;
                end
            end
            WRITE: begin
                for (int i = 0; i < DIMY * SLOTS; i++) begin
                    write_en[i] = (i == int'(r_row) * SLOTS + int'(r_slot));
                end
                w_next = (w_slot_last && w_row_last) ? DONE : LOAD;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Counters freeze at the last row/slot on the final write; start clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row  <= '0;
            r_slot <= '0;
        end else if (w_start_load) begin
            r_row  <= '0;
            r_slot <= '0;
        end else if (r_state == WRITE) begin
            if (!w_slot_last) begin
                r_slot <= r_slot + 1'b1;
            end else if (!w_row_last) begin
                r_slot <= '0;
                r_row  <= r_row + 1'b1;
            end
        end
    end

    // NOTE: the row bus is a plain flop bank, not a RAM macro, so it takes the
    // asynchronous clear like any other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ram <= '0;
        end else if (w_accept) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (s == int'(r_slot)) begin
                    r_ram[s*PORT_WIDTH +: PORT_WIDTH] <= in_data;
                end
            end
        end
    end

`ifdef CELL_LOADER_CHECKSUM_EN
    logic [PORT_WIDTH-1:0] r_checksum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_start_load) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum ^ in_data;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_cell_loader.sv
// Randomized scoreboard bench for cell_loader (DIMX=16, DIMY=2, PORT_WIDTH=32).
// Expected slot writes and done pulses are queued by the driver and popped by a monitor.
module tb_cell_loader;

    localparam int DIMX  = 16;
    localparam int DIMY  = 2;
    localparam int PW    = 32;
    localparam int SLOTS = 2;
    localparam int TOTAL = DIMY * SLOTS;
    localparam int RAMW  = DIMX * 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [PW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic [RAMW-1:0]   ram;
    logic [TOTAL-1:0]  write_en;
    logic              busy;
    logic              done;
`ifdef CELL_LOADER_CHECKSUM_EN
    logic [PW-1:0]     checksum;
`endif

    cell_loader #(
        .DIMX       (DIMX),
        .DIMY       (DIMY),
        .PORT_WIDTH (PW),
        .SLOTS      (SLOTS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ram      (ram),
        .write_en (write_en),
        .busy     (busy),
        .done     (done)
`ifdef CELL_LOADER_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int              idx;
        logic [RAMW-1:0] ram;
        int              cyc;
    } wr_t;

    wr_t             exp_wr[$];
    int              exp_done[$];
    int              cyc = 0;
    int              n_checks = 0;
    int              n_fail = 0;
    logic            prev_done = 1'b0;

    // Reference model: the array as a flat sequence of TOTAL words filling slots in order.
    logic [RAMW-1:0] m_ram;
    logic [PW-1:0]   m_sum;
    int              m_k;
    bit              m_active;

    logic [PW-1:0]   ld_w[TOTAL];
    int              ld_gap[TOTAL];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (write_en !== '0) begin
                check("we_onehot", 128'($countones(write_en)), 128'd1);
                check("we_in_ready_low", in_ready, 1'b0);
                if (exp_wr.size() == 0) begin
                    check("we_unexpected", write_en, '0);
                end else begin
                    wr_t e;
                    logic [TOTAL-1:0] we_exp;
                    e = exp_wr.pop_front();
                    we_exp = '0;
                    we_exp[e.idx] = 1'b1;
                    check("we_bits", write_en, we_exp);
                    check("we_ram", ram, e.ram);
                    check("we_latency", 128'(cyc), 128'(e.cyc));
                end
            end
            if (done === 1'b1) begin
                check("done_busy", busy, 1'b1);
                if (exp_done.size() == 0) begin
                    check("done_unexpected", done, 1'b0);
                end else begin
                    check("done_cycle", 128'(cyc), 128'(exp_done.pop_front()));
                end
            end
            if (prev_done) begin
                check("busy_after_done", busy, 1'b0);
            end
            prev_done <= done;
        end
    end

    task automatic model_clear();
        m_ram    = '0;
        m_sum    = '0;
        m_k      = 0;
        m_active = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        if (!m_active) begin
            m_active = 1'b1;
            m_k      = 0;
            m_sum    = '0;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [PW-1:0] w);
        int budget;
        int slot;
        wr_t e;
        budget   = 50;
        in_valid = 1'b1;
        in_data  = w;
        while (in_ready !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            check("in_ready_timeout", in_ready, 1'b1);
            in_valid = 1'b0;
            return;
        end
        slot = m_k % SLOTS;
        m_ram[slot*PW +: PW] = w;
        m_sum = m_sum ^ w;
        e.idx = m_k;
        e.ram = m_ram;
        e.cyc = cyc + 1;
        exp_wr.push_back(e);
        m_k++;
        if (m_k == TOTAL) begin
            exp_done.push_back(cyc + 2);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic wait_done();
        int budget;
        budget = 20;
        while (exp_done.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            check("done_timeout", 128'(exp_done.size()), 128'd0);
            exp_done.delete();
        end
        @(negedge clk);
        m_active = 1'b0;
        check("final_busy", busy, 1'b0);
        check("final_ram", ram, m_ram);
`ifdef CELL_LOADER_CHECKSUM_EN
        check("final_checksum", checksum, m_sum);
`endif
    endtask

    task automatic run_load(input int restart_after);
        do_start();
        check("busy_after_start", busy, 1'b1);
        for (int i = 0; i < TOTAL; i++) begin
            if (ld_gap[i] > 0 && i > 0) begin
                @(negedge clk);
            end
            for (int g = 0; g < ld_gap[i]; g++) begin
                check("stall_in_ready", in_ready, 1'b1);
                @(negedge clk);
            end
            send_word(ld_w[i]);
            if (i == restart_after) begin
                do_start();
            end
        end
        wait_done();
    endtask

    task automatic set_fixed(input logic [PW-1:0] fill);
        for (int i = 0; i < TOTAL; i++) begin
            ld_w[i]   = (fill == '0) ? PW'((i + 1) * 32'h1111_1111) : fill;
            ld_gap[i] = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        model_clear();
        #1 reset = 1'b1;
        #1;
        check("rst_write_en", write_en, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_ram", ram, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back load of 0x11111111..0x44444444.
        set_fixed('0);
        run_load(-1);

        // Same load with a five-cycle stall before the third word.
        set_fixed('0);
        ld_gap[2] = 5;
        run_load(-1);

        // Start pulsed again after the first word must be ignored.
        set_fixed('0);
        run_load(0);

        // All-ones load: checksum of four identical words is zero.
        set_fixed(32'hFFFF_FFFF);
        run_load(-1);

        // Reset while the second word is in its write cycle.
        set_fixed('0);
        do_start();
        send_word(ld_w[0]);
        send_word(ld_w[1]);
        #2 reset = 1'b1;
        #1;
        check("midrst_write_en", write_en, '0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ram", ram, '0);
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_pending", 128'(exp_wr.size()), 128'd0);
        exp_wr.delete();
        exp_done.delete();
        model_clear();
`ifdef CELL_LOADER_CHECKSUM_EN
        check("midrst_checksum", checksum, '0);
`endif
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_load(-1);

        // Randomized loads with random stalls and spurious starts.
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < TOTAL; i++) begin
                ld_w[i]   = $urandom;
                ld_gap[i] = int'($urandom_range(0, 3));
            end
            run_load(int'($urandom_range(0, TOTAL)) - 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("left_writes", 128'(exp_wr.size()), 128'd0);
        check("left_dones", 128'(exp_done.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
